data_mem_responder: RTL

//  Responder side of the core's data-memory interface: accepts DataAdr/WriteData/MemWrite

---
 rtl/data_mem_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus LED/cycle-counter I/O, with configurable wait states.
// Stall, ReadData and Fault are combinational views of the current completion state.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic [7:0]  Leds,
  output logic        Fault
);
  localparam int unsigned DW         = 32;
  localparam int unsigned LW         = 8;
  localparam int unsigned AW         = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);
  localparam int unsigned CW         = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [DW-1:0] RAM_BYTES = DW'(DEPTH_WORDS * 4);
  localparam logic [DW-1:0] LED_ADR   = IO_BASE;
  localparam logic [DW-1:0] CYC_ADR   = IO_BASE + 32'd4;
  localparam bit          ZERO_WS    = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_accept;
  logic            w_last;

  logic [DW-1:0]   r_adr;
  logic [DW-1:0]   r_wdata;
  logic            r_write;
  logic [LW-1:0]   r_leds;
  logic [DW-1:0]   r_cycle;
  logic [DW-1:0]   r_mem [DEPTH_WORDS];

  logic [DW-1:0]   w_adr;
  logic [DW-1:0]   w_wdata;
  logic            w_write;
  logic            w_complete;
  logic            w_misalign;
  logic            w_hit_ram;
  logic            w_hit_led;
  logic            w_hit_cyc;
  logic            w_bad;
  logic            w_commit;
  logic [AW-1:0]   w_idx;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // r_cnt holds the number of stall cycles already spent; the request cycle is the first
  assign w_last = (32'(r_cnt) + 32'd1) >= WAIT_STATES;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MemReq && !ZERO_WS) begin
          w_accept   = 1'b1;
          w_cnt_next = CW'(1);
          w_next     = (WAIT_STATES == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!MemReq) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
          if (w_last) w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // Request capture so the access uses the values presented in the request cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_adr   <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_adr   <= DataAdr;
      r_wdata <= WriteData;
      r_write <= MemWrite;
    end
  end

  assign Stall      = MemReq && (r_state != S_DONE) && !ZERO_WS;
  assign w_complete = ZERO_WS ? MemReq    : (r_state == S_DONE);
  assign w_adr      = ZERO_WS ? DataAdr   : r_adr;
  assign w_wdata    = ZERO_WS ? WriteData : r_wdata;
  assign w_write    = ZERO_WS ? MemWrite  : r_write;

  // Address decode
  assign w_misalign = |w_adr[1:0];
  assign w_hit_ram  = !w_misalign && (w_adr < RAM_BYTES);
  assign w_hit_led  = !w_misalign && (w_adr == LED_ADR);
  assign w_hit_cyc  = !w_misalign && (w_adr == CYC_ADR);
  assign w_bad      = !(w_hit_ram || w_hit_led || w_hit_cyc);
  assign w_idx      = w_adr[AW+1:2];
  assign w_commit   = w_complete && w_write && reset && !w_bad;

  always_comb begin
    ReadData = '0;
    Fault    = 1'b0;
    if (w_complete) begin
      if (w_bad) begin
        Fault = 1'b1;
      end else if (!w_write) begin
        if (w_hit_ram)      ReadData = r_mem[w_idx];
        else if (w_hit_led) ReadData = {24'b0, r_leds};
        else                ReadData = r_cycle;
      end
    end
  end

  // RAM has no reset: contents survive reset
  always_ff @(posedge clk) begin
    if (w_commit && w_hit_ram) r_mem[w_idx] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_leds <= '0;
    end else if (w_commit && w_hit_led) begin
      r_leds <= w_wdata[LW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end

  assign Leds = r_leds;

endmodule
